// File: rtl/ftf_encoder_03.sv
// rtl/ftf_encoder_03.sv - 3-wire FTF Fibonacci-numeral-system encoder with loopback decoder
// Symbols 0..4 map onto codewords that never place a forbidden transition across adjacent TSVs.

module ftf_dec03 #(
  parameter int FBLEN03 = 3,
  parameter int TSVW    = 3
) (
  input  logic [TSVW-1:0]    tsv_i,
  output logic [FBLEN03-1:0] data_o
);

  // Weighted sum with weights 1,1,2; defined for every code, including fault-only ones.
  always_comb begin
    data_o = {{(FBLEN03-1){1'b0}}, tsv_i[0]}
           + {{(FBLEN03-1){1'b0}}, tsv_i[1]}
           + {{(FBLEN03-2){1'b0}}, tsv_i[2], 1'b0};
  end

endmodule

module ftf_encoder_03 #(
  parameter int FBLEN03 = 3,
  parameter int TSVW    = 3
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [FBLEN03-1:0] datain,
  output logic [TSVW-1:0]    tsv,
  output logic [FBLEN03-1:0] dataout,
  output logic               invalid
);

  localparam logic [FBLEN03-1:0] SYM_MAX = FBLEN03'(4);

  logic [TSVW-1:0]    tsv_q, tsv_d;
  logic               invalid_q, invalid_d;
  logic [FBLEN03-1:0] sym_sat;
  logic [FBLEN03-1:0] rem;

  // Out-of-range symbols saturate to the top code and raise invalid on the same edge.
  always_comb begin
    invalid_d = 1'b0;
    sym_sat   = datain;
    if (datain > SYM_MAX) begin
      invalid_d = 1'b1;
      sym_sat   = SYM_MAX;
    end
  end

  always_comb begin
    tsv_d    = '0;
    tsv_d[2] = (sym_sat >= FBLEN03'(2));
    rem      = sym_sat - {{(FBLEN03-2){1'b0}}, tsv_d[2], 1'b0};
    tsv_d[0] = (rem >= FBLEN03'(1));
    tsv_d[1] = (rem == FBLEN03'(2));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tsv_q     <= '0;
      invalid_q <= 1'b0;
    end else begin
      tsv_q     <= tsv_d;
      invalid_q <= invalid_d;
    end
  end

  assign tsv     = tsv_q;
  assign invalid = invalid_q;

  ftf_dec03 #(
    .FBLEN03 (FBLEN03),
    .TSVW    (TSVW)
  ) u_dec (
    .tsv_i  (tsv_q),
    .data_o (dataout)
  );

endmodule

// File: tb/tb_ftf_encoder_03.sv
// tb/tb_ftf_encoder_03.sv - self-checking bench for ftf_encoder_03

module tb_ftf_encoder_03;

  logic       clock;
  logic       reset_n;
  logic [2:0] datain;
  logic [2:0] tsv;
  logic [2:0] dataout;
  logic       invalid;
  logic [2:0] dec_in;
  logic [2:0] dec_out;

  int n_cmp;
  int n_err;

  ftf_encoder_03 dut (
    .clock   (clock),
    .reset_n (reset_n),
    .datain  (datain),
    .tsv     (tsv),
    .dataout (dataout),
    .invalid (invalid)
  );

  ftf_dec03 u_dec_alone (
    .tsv_i  (dec_in),
    .data_o (dec_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [2:0] ref_code(input int d);
    logic [2:0] book [0:4];
    int s;
    book[0] = 3'b000; book[1] = 3'b001; book[2] = 3'b100;
    book[3] = 3'b101; book[4] = 3'b111;
    s = (d > 4) ? 4 : d;
    return book[s];
  endfunction

  function automatic logic [2:0] ref_decode(input logic [2:0] t);
    int v;
    v = int'(t[0]) + int'(t[1]) + 2 * int'(t[2]);
    return 3'(v);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    datain  = 3'd4;
    repeat (3) step();
    n_cmp++;
    if (tsv !== 3'b000) begin n_err++; $display("FAIL reset_tsv got=%b exp=000", tsv); end
    n_cmp++;
    if (dataout !== 3'd0) begin n_err++; $display("FAIL reset_dataout got=%0d exp=0", dataout); end
    n_cmp++;
    if (invalid !== 1'b0) begin n_err++; $display("FAIL reset_invalid got=%b exp=0", invalid); end
    #2 reset_n = 1'b1;
    step();
    n_cmp++;
    if (tsv !== 3'b111) begin n_err++; $display("FAIL first_capture got=%b exp=111", tsv); end
  endtask

  task automatic test_async_reset();
    datain = 3'd4;
    step();
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (tsv !== 3'b000) begin n_err++; $display("FAIL async_reset_tsv got=%b exp=000", tsv); end
    n_cmp++;
    if (dataout !== 3'd0) begin n_err++; $display("FAIL async_reset_dataout got=%0d exp=0", dataout); end
    #1 reset_n = 1'b1;
    step();
    n_cmp++;
    if (tsv !== 3'b111) begin n_err++; $display("FAIL post_async_capture got=%b exp=111", tsv); end
  endtask

  task automatic test_legal();
    for (int d = 0; d <= 4; d++) begin
      datain = 3'(d);
      step();
      n_cmp++;
      if (tsv !== ref_code(d)) begin n_err++; $display("FAIL legal_tsv d=%0d got=%b exp=%b", d, tsv, ref_code(d)); end
      n_cmp++;
      if (dataout !== 3'(d)) begin n_err++; $display("FAIL legal_dataout d=%0d got=%0d exp=%0d", d, dataout, d); end
      n_cmp++;
      if (invalid !== 1'b0) begin n_err++; $display("FAIL legal_invalid d=%0d got=%b exp=0", d, invalid); end
    end
  endtask

  task automatic test_random();
    int ftf_errs;
    int d;
    ftf_errs = 0;
    for (int i = 0; i < 1000; i++) begin
      d = int'($urandom_range(0, 4));
      datain = 3'(d);
      step();
      if (dataout !== 3'(d) || tsv !== ref_code(d) || invalid !== 1'b0) ftf_errs++;
      if (tsv[1:0] == 2'b10 || tsv[2:1] == 2'b01) ftf_errs++;
    end
    n_cmp++;
    if (ftf_errs != 0) begin n_err++; $display("FAIL random_ftf errors got=%0d exp=0", ftf_errs); end
  endtask

  task automatic test_saturation();
    for (int d = 5; d <= 7; d++) begin
      datain = 3'(d);
      step();
      n_cmp++;
      if (tsv !== 3'b111) begin n_err++; $display("FAIL sat_tsv d=%0d got=%b exp=111", d, tsv); end
      n_cmp++;
      if (dataout !== 3'd4) begin n_err++; $display("FAIL sat_dataout d=%0d got=%0d exp=4", d, dataout); end
      n_cmp++;
      if (invalid !== 1'b1) begin n_err++; $display("FAIL sat_invalid d=%0d got=%b exp=1", d, invalid); end
    end
    datain = 3'd2;
    step();
    n_cmp++;
    if (tsv !== 3'b100) begin n_err++; $display("FAIL sat_recover_tsv got=%b exp=100", tsv); end
    n_cmp++;
    if (dataout !== 3'd2) begin n_err++; $display("FAIL sat_recover_dataout got=%0d exp=2", dataout); end
    n_cmp++;
    if (invalid !== 1'b0) begin n_err++; $display("FAIL sat_recover_invalid got=%b exp=0", invalid); end
  endtask

  task automatic test_decoder();
    logic [2:0] t;
    for (int i = 0; i < 8; i++) begin
      t = 3'(i);
      dec_in = t;
      #1;
      n_cmp++;
      if (dec_out !== ref_decode(t)) begin n_err++; $display("FAIL decode tsv=%b got=%0d exp=%0d", t, dec_out, ref_decode(t)); end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    for (int i = 0; i < 10; i++) begin
      d = (i % 2 == 0) ? 0 : 4;
      datain = 3'(d);
      step();
      n_cmp++;
      if (tsv !== ref_code(d)) begin n_err++; $display("FAIL b2b_tsv i=%0d got=%b exp=%b", i, tsv, ref_code(d)); end
      n_cmp++;
      if (dataout !== 3'(d)) begin n_err++; $display("FAIL b2b_dataout i=%0d got=%0d exp=%0d", i, dataout, d); end
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    datain  = 3'd0;
    dec_in  = 3'd0;
    test_reset();
    test_legal();
    test_async_reset();
    test_random();
    test_saturation();
    test_decoder();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
